// File: rtl/wbuf_merge_queue.sv
// Write-combining store buffer: circular FIFO of word-tagged entries with
// youngest-entry byte merging, flush handshake and load hazard lookup.
module wbuf_merge_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MERGE_EN   = 1,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [ADDR_WIDTH-1:0]         push_addr_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic [BE_WIDTH-1:0]           push_be_i,
    output logic                          drain_valid_o,
    input  logic                          drain_ready_i,
    output logic [ADDR_WIDTH-1:0]         drain_addr_o,
    output logic [DATA_WIDTH-1:0]         drain_data_o,
    output logic [BE_WIDTH-1:0]           drain_be_o,
    input  logic [ADDR_WIDTH-1:0]         chk_addr_i,
    input  logic [BE_WIDTH-1:0]           chk_be_i,
    output logic                          chk_hit_o,
    input  logic                          flush_i,
    output logic                          flush_done_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OFF_W = $clog2(BE_WIDTH);
    localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W;

    logic [TAG_W-1:0]      tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [BE_WIDTH-1:0]   be_q   [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q, last_ptr;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             pend_q, pend_nxt, done_q, empty_q;
    logic [TAG_W-1:0] push_tag, chk_tag;
    logic             merge_hit, full, push_fire, has_be, alloc, merge, pop;
    logic             unused_addr_bits;

    assign push_tag = push_addr_i[ADDR_WIDTH-1:OFF_W];
    assign chk_tag  = chk_addr_i[ADDR_WIDTH-1:OFF_W];
    assign last_ptr = tail_q - PTR_W'(1);
    assign unused_addr_bits = ^{push_addr_i, chk_addr_i};

    // The head is excluded as a merge target by requiring at least two entries.
    assign merge_hit = (MERGE_EN != 0) && (count_q >= CNT_W'(2)) && (tag_q[last_ptr] == push_tag);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push_ready_o = !rst_i && !pend_q && (!full || merge_hit);

    assign push_fire = push_valid_i && push_ready_o;
    assign has_be    = |push_be_i;
    assign alloc     = push_fire && !merge_hit && has_be;
    assign merge     = push_fire && merge_hit && has_be;
    assign pop       = (count_q != '0) && drain_ready_i;

    assign count_nxt = count_q + CNT_W'(alloc) - CNT_W'(pop);
    assign pend_nxt  = (pend_q && count_q == '0) ? 1'b0 : (pend_q || flush_i);

    // Entry storage; contents are don't-care until allocated, so no reset.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= push_data_i;
            be_q[tail_q]   <= push_be_i;
        end
        if (merge) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (push_be_i[b]) begin
                    data_q[last_ptr][b*8 +: 8] <= push_data_i[b*8 +: 8];
                end
            end
            be_q[last_ptr] <= be_q[last_ptr] | push_be_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (alloc) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            count_q <= count_nxt;
            pend_q  <= pend_nxt;
            done_q  <= pend_nxt && (count_nxt == '0);
            empty_q <= (count_nxt == '0);
        end
    end

    assign drain_valid_o = (count_q != '0);
    assign drain_addr_o  = drain_valid_o ? (ADDR_WIDTH'(tag_q[head_q]) << OFF_W) : '0;
    assign drain_data_o  = drain_valid_o ? data_q[head_q] : '0;
    assign drain_be_o    = drain_valid_o ? be_q[head_q] : '0;
    assign flush_done_o  = done_q;
    assign count_o       = count_q;
    assign empty_o       = empty_q;

    // Load hazard lookup over occupied slots only (offset from head < count).
    always_comb begin
        logic [PTR_W-1:0] off;
        chk_hit_o = 1'b0;
        off       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PTR_W'(i) - head_q;
            if ((CNT_W'(off) < count_q) && (tag_q[i] == chk_tag) && (|(be_q[i] & chk_be_i))) begin
                chk_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wbuf_merge_queue.sv
// Directed bench for wbuf_merge_queue: queue-level reference model checked
// every negedge, plus literal expectations at key points of each scenario.
module tb_wbuf_merge_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [63:0] push_addr = '0;
    logic [63:0] push_data = '0;
    logic [7:0]  push_be = '0;
    logic        drain_valid;
    logic        drain_ready = 1'b0;
    logic [63:0] drain_addr;
    logic [63:0] drain_data;
    logic [7:0]  drain_be;
    logic [63:0] chk_addr = '0;
    logic [7:0]  chk_be = '0;
    logic        chk_hit;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [3:0]  count;
    logic        empty;

    int passed = 0;
    int total  = 0;

    wbuf_merge_queue #(.DEPTH(8), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MERGE_EN(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .push_valid_i(push_valid), .push_ready_o(push_ready),
        .push_addr_i(push_addr), .push_data_i(push_data), .push_be_i(push_be),
        .drain_valid_o(drain_valid), .drain_ready_i(drain_ready),
        .drain_addr_o(drain_addr), .drain_data_o(drain_data), .drain_be_o(drain_be),
        .chk_addr_i(chk_addr), .chk_be_i(chk_be), .chk_hit_o(chk_hit),
        .flush_i(flush), .flush_done_o(flush_done),
        .count_o(count), .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: ordered list of pending word-aligned stores.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } ent_t;

    ent_t q[$];
    bit   m_pend = 1'b0;

    function automatic bit model_merge_hit();
        logic [63:0] a;
        if (q.size() < 2) return 1'b0;
        a = q[q.size()-1].addr;
        return (push_addr[63:3] == a[63:3]);
    endfunction

    function automatic bit model_ready();
        return !rst && !m_pend && (q.size() < 8 || model_merge_hit());
    endfunction

    function automatic bit model_hit();
        logic [63:0] a;
        foreach (q[i]) begin
            a = q[i].addr;
            if (a[63:3] == chk_addr[63:3] && (q[i].be & chk_be) != 8'h00) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            bit   mh, rdy, do_pop, done_now;
            ent_t e;
            mh       = model_merge_hit();
            rdy      = model_ready();
            do_pop   = (q.size() != 0) && drain_ready;
            done_now = m_pend && (q.size() == 0);
            if (push_valid && rdy && push_be != 8'h00 && mh) begin
                e = q[q.size()-1];
                for (int b = 0; b < 8; b++)
                    if (push_be[b]) e.data[b*8 +: 8] = push_data[b*8 +: 8];
                e.be = e.be | push_be;
                q[q.size()-1] = e;
            end
            if (do_pop) void'(q.pop_front());
            if (push_valid && rdy && push_be != 8'h00 && !mh) begin
                e.addr = {push_addr[63:3], 3'b000};
                e.data = push_data;
                e.be   = push_be;
                q.push_back(e);
            end
            if (done_now) m_pend = 1'b0;
            else if (flush) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("drain_valid", 64'(drain_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("drain_addr", drain_addr, q[0].addr);
            chk("drain_data", drain_data, q[0].data);
            chk("drain_be", 64'(drain_be), 64'(q[0].be));
        end
        chk("flush_done", 64'(flush_done), 64'(m_pend && q.size() == 0));
        chk("push_ready", 64'(push_ready), 64'(model_ready()));
        chk("chk_hit", 64'(chk_hit), 64'(model_hit()));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        push_be    = be;
        step();
        push_valid = 1'b0;
    endtask

    task automatic drain_all();
        drain_ready = 1'b1;
        repeat (10) step();
        drain_ready = 1'b0;
    endtask

    int dones;
    logic [3:0] cnt_at_done;

    initial begin
        repeat (2) step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_push_ready", 64'(push_ready), 64'd0);
        rst = 1'b0;
        step();

        // In-order drain
        push_one(64'h1000, 64'h0101_0101_0101_0101, 8'hFF);
        push_one(64'h2000, 64'h0202_0202_0202_0202, 8'hFF);
        push_one(64'h3000, 64'h0303_0303_0303_0303, 8'hFF);
        chk("fifo_count3", 64'(count), 64'd3);
        chk("fifo_head", drain_addr, 64'h1000);
        drain_ready = 1'b1;
        chk("fifo_pop0", drain_addr, 64'h1000);
        step();
        chk("fifo_pop1", drain_addr, 64'h2000);
        step();
        chk("fifo_pop2", drain_addr, 64'h3000);
        step();
        chk("fifo_empty", 64'(empty), 64'd1);
        drain_ready = 1'b0;

        // Merge into youngest
        push_one(64'h1000, 64'h1111_1111_2222_2222, 8'h0F);
        push_one(64'h2000, 64'h3333_3333_4444_4444, 8'h0F);
        push_one(64'h2004, 64'hAAAA_AAAA_0000_0000, 8'hF0);
        chk("merge_count", 64'(count), 64'd2);
        drain_ready = 1'b1;
        chk("merge_head", drain_addr, 64'h1000);
        step();
        chk("merge_addr", drain_addr, 64'h2000);
        chk("merge_data", drain_data, 64'hAAAA_AAAA_4444_4444);
        chk("merge_be", 64'(drain_be), 64'hFF);
        step();
        drain_ready = 1'b0;

        // Full buffer, merge into youngest still accepted
        for (int k = 1; k <= 8; k++) push_one(64'(k) * 64'h100, 64'(k), 8'h0F);
        push_valid = 1'b1;
        push_addr  = 64'h4000;
        push_data  = 64'hBBBB_BBBB_0000_0000;
        push_be    = 8'hF0;
        #1 chk("full_ready", 64'(push_ready), 64'd0);
        push_addr = 64'h804;
        #1 chk("full_merge_ready", 64'(push_ready), 64'd1);
        step();
        push_valid = 1'b0;
        chk("full_count", 64'(count), 64'd8);
        drain_all();
        push_one(64'h500, 64'h0000_0000_5555_5555, 8'h0F);
        push_one(64'h504, 64'h6666_6666_0000_0000, 8'hF0);
        chk("count1_no_merge", 64'(count), 64'd2);
        drain_all();

        // Flush with pushes held off
        for (int k = 0; k < 4; k++) push_one(64'h8000 + 64'(k) * 64'h10, 64'(k), 8'hFF);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_addr  = 64'h9000;
        push_data  = 64'h9999;
        push_be    = 8'hFF;
        step();
        flush = 1'b0;
        chk("flush_block", 64'(push_ready), 64'd0);
        drain_ready = 1'b1;
        dones = 0;
        cnt_at_done = 4'hF;
        for (int k = 0; k < 10; k++) begin
            step();
            if (flush_done) begin
                dones++;
                cnt_at_done = count;
            end
        end
        push_valid = 1'b0;
        chk("flush_pulses", 64'(dones), 64'd1);
        chk("flush_done_count", 64'(cnt_at_done), 64'd0);
        drain_all();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty_done", 64'(flush_done), 64'd1);
        step();
        chk("flush_empty_clear", 64'(flush_done), 64'd0);

        // Hazard check
        push_one(64'h1000, 64'h0, 8'h0F);
        chk_addr = 64'h1004;
        chk_be   = 8'hF0;
        #1 chk("haz_disjoint", 64'(chk_hit), 64'd0);
        chk_be = 8'h01;
        #1 chk("haz_overlap", 64'(chk_hit), 64'd1);
        chk_addr = 64'h1008;
        #1 chk("haz_other_word", 64'(chk_hit), 64'd0);
        chk_addr = '0;
        chk_be   = '0;
        drain_all();

        // Asynchronous reset mid-drain with flush pending
        for (int k = 0; k < 6; k++) push_one(64'hA000 + 64'(k) * 64'h8, 64'(k), 8'hFF);
        flush = 1'b1;
        drain_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_valid", 64'(drain_valid), 64'd0);
        chk("arst_addr", drain_addr, 64'd0);
        chk("arst_ready", 64'(push_ready), 64'd0);
        step();
        rst = 1'b0;
        drain_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_no_done", 64'(flush_done), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wbuf_merge_queue.md
Name: wbuf_merge_queue

Overview:
- Parametrised write-combining store buffer between the store unit and the data-cache/NoC write port.
- Generalises the fixed-depth write buffer: configurable depth, address and data width, optional merging of byte-enabled stores into the youngest entry, explicit flush, and a load hazard check.
- Drains entries strictly in FIFO order through a valid/ready port.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, entry data width; multiple of 8.
- MERGE_EN, 1, 1 enables write combining; 0 gives a pure FIFO.
- BE_WIDTH, DATA_WIDTH/8, derived; must not be overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- push_valid_i  in  1  store request
- push_ready_o  out  1  buffer accepts store
- push_addr_i  in  ADDR_WIDTH  byte address; low log2(BE_WIDTH) bits ignored
- push_data_i  in  DATA_WIDTH  word-aligned store data
- push_be_i  in  BE_WIDTH  byte enables
- drain_valid_o  out  1  head entry valid
- drain_ready_i  in  1  downstream accepts head
- drain_addr_o  out  ADDR_WIDTH  head word address (low bits zero)
- drain_data_o  out  DATA_WIDTH  head data
- drain_be_o  out  BE_WIDTH  head byte enables
- chk_addr_i  in  ADDR_WIDTH  load address for hazard check
- chk_be_i  in  BE_WIDTH  load byte mask
- chk_hit_o  out  1  some valid entry overlaps the load
- flush_i  in  1  drain-all request (pulse)
- flush_done_o  out  1  one-cycle pulse when the flush completes
- count_o  out  $clog2(DEPTH+1)  occupied entries
- empty_o  out  1  count_o == 0

Behaviour:
- Storage is a circular buffer with head and tail pointers of width log2(DEPTH). Entry tag = addr[ADDR_WIDTH-1:log2(BE_WIDTH)].
- Reset (asynchronous, any cycle, including mid-flush or mid-drain):
  - head, tail and count go to 0; flush_pending is cleared.
  - All outputs go to 0 except empty_o, which goes to 1.
  - Entry contents are don't-care.
- Drain:
  - drain_valid_o = (count != 0).
  - Head addr, data and be are registered and stay stable while drain_valid_o && !drain_ready_i.
  - A pop happens when drain_valid_o && drain_ready_i.
- Merge:
  - A merge hit requires MERGE_EN, count >= 2, and the push tag equal to the youngest entry's (tail-1) tag.
  - The head is never a merge target, so drain outputs never change under a pending handshake.
  - On a merge, for each byte b with push_be_i[b] set: data byte b is overwritten and be[b] is set. count is unchanged.
- Push:
  - push_ready_o = !flush_pending && (count < DEPTH || merge_hit). This is combinational from push_addr_i and registered state.
  - push_ready_o does not depend on drain_ready_i: a full, non-merging push waits one cycle even if a pop occurs in the same cycle.
  - A push that does not merge writes a new entry at the tail and sets tail <= tail+1.
- Simultaneous push and pop: count' = count + alloc - pop. A merge together with a pop is legal because it requires count >= 2.
- A push with push_be_i == 0 is accepted and completes with no state change. This is not an error.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Flush:
  - flush_i sets flush_pending; pushes are blocked while it is set.
  - flush_done_o pulses in the first cycle where flush_pending && count == 0, and flush_pending clears in that same cycle.
  - flush_i while already empty gives flush_done_o on the next cycle.
  - flush_i while flush_pending is already set is absorbed.
- Hazard check: chk_hit_o is combinational. It is 1 if any valid entry has tag == chk tag and (be & chk_be_i) != 0. It ignores the push in flight this cycle.
- count_o and empty_o are registered and reflect state after the previous edge.

Test Plan:
- Reset, then push 3 stores at 0x1000, 0x2000, 0x3000 with be=0xFF; hold drain_ready_i=0 → count_o=3, drain_addr_o=0x1000. Raise drain_ready_i → pops in order 0x1000, 0x2000, 0x3000; empty_o=1 after the third pop.
- MERGE_EN=1:
  - Push 0x1000 be=0x0F data=0x11111111_22222222, then push 0x2000 be=0x0F.
  - Push 0x2004 be=0xF0 data=0xAAAAAAAA_00000000 → count stays 2.
  - Second drained entry has be=0xFF and data=0xAAAAAAAA_<low word of first 0x2000 push>.
- Fill all 8 entries with distinct tags, hold drain_ready_i=0 → push_ready_o=0. A push with the same tag as tail-1 → push_ready_o=1 and merges. With count=1, a same-tag push allocates a new entry instead of merging.
- With 4 entries pending, pulse flush_i and keep push_valid_i=1 → push_ready_o=0 until done; drain 4 at one per cycle → flush_done_o pulses exactly once, in the cycle count_o becomes 0.
- Hazard check with entry 0x1000 be=0x0F:
  - chk_addr_i=0x1004, chk_be_i=0xF0 → chk_hit_o=0.
  - chk_be_i=0x01 → chk_hit_o=1.
  - chk_addr_i=0x1008 → chk_hit_o=0.
- Assert rst_i asynchronously mid-drain with count=5 and flush_pending set → outputs reach reset values before the next edge; no flush_done_o pulse after reset is released.
